// File: rtl/cpu_controller.sv
// Control stage: instruction register plus Moore FSM sequencing the datapath (MOV/ADD/CMP/AND/MVN).
// Optional build macro CPU_CTRL_STATUS_ALL_EN: load the Z status register on every ALU step.
module cpu_controller #(
   parameter logic [15:0] RESET_IR = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] in,
   input  logic        load,
   input  logic        s,
   output logic        w,
   output logic        bad_op,
   output logic [15:0] datapath_in,
   output logic        vsel,
   output logic [2:0]  writenum,
   output logic        write,
   output logic [2:0]  readnum,
   output logic        loada,
   output logic        loadb,
   output logic [1:0]  shift,
   output logic [1:0]  ALUop,
   output logic        loadc,
   output logic        loads,
   output logic        asel,
   output logic        bsel,
   output logic [2:0]  o_dbg_state
);

   localparam logic [2:0] S_WAIT = 3'd0;
   localparam logic [2:0] S_GETA = 3'd1;
   localparam logic [2:0] S_GETB = 3'd2;
   localparam logic [2:0] S_ALU  = 3'd3;
   localparam logic [2:0] S_WREG = 3'd4;
   localparam logic [2:0] S_WIMM = 3'd5;

   logic [2:0]  r_state;
   logic [2:0]  w_next;
   logic [15:0] r_ir;
   logic        r_bad_op;

   logic [2:0]  w_op;
   logic [1:0]  w_sub;
   logic [2:0]  w_rn;
   logic [2:0]  w_rd;
   logic [1:0]  w_sh;
   logic [2:0]  w_rm;
   logic        w_is_mov_imm;
   logic        w_is_mov_reg;
   logic        w_is_alu_grp;
   logic        w_is_cmp;
   logic        w_is_mvn;
   logic        w_valid;
   logic        w_start;

   assign w_op  = r_ir[15:13];
   assign w_sub = r_ir[12:11];
   assign w_rn  = r_ir[10:8];
   assign w_rd  = r_ir[7:5];
   assign w_sh  = r_ir[4:3];
   assign w_rm  = r_ir[2:0];

   assign w_is_mov_imm = (w_op == 3'b110) && (w_sub == 2'b10);
   assign w_is_mov_reg = (w_op == 3'b110) && (w_sub == 2'b00);
   assign w_is_alu_grp = (w_op == 3'b101);
   assign w_is_cmp     = w_is_alu_grp && (w_sub == 2'b01);
   assign w_is_mvn     = w_is_alu_grp && (w_sub == 2'b11);
   assign w_valid      = w_is_mov_imm || w_is_mov_reg || w_is_alu_grp;
   assign w_start      = (r_state == S_WAIT) && s;

   // s wins over a same-cycle load so the instruction being started keeps its IR throughout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ir <= RESET_IR;
      end else if ((r_state == S_WAIT) && load && !s) begin
         r_ir <= in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_WAIT;
         r_bad_op <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_bad_op <= w_start && !w_valid;
      end
   end

   always_comb begin
      w_next = S_WAIT;
      case (r_state)
         S_WAIT: begin
            if (!s)                                w_next = S_WAIT;
            else if (w_is_mov_imm)                 w_next = S_WIMM;
            else if (w_is_mov_reg || w_is_mvn)     w_next = S_GETB;
            else if (w_is_alu_grp)                 w_next = S_GETA;
            else                                   w_next = S_WAIT;
         end
         S_GETA:  w_next = S_GETB;
         S_GETB:  w_next = S_ALU;
         S_ALU:   w_next = w_is_cmp ? S_WAIT : S_WREG;
         S_WREG:  w_next = S_WAIT;
         S_WIMM:  w_next = S_WAIT;
         default: w_next = S_WAIT;
      endcase
   end

   always_comb begin
      w        = 1'b0;
      vsel     = 1'b0;
      writenum = 3'd0;
      write    = 1'b0;
      readnum  = 3'd0;
      loada    = 1'b0;
      loadb    = 1'b0;
      shift    = 2'b00;
      ALUop    = 2'b00;
      loadc    = 1'b0;
      loads    = 1'b0;
      asel     = 1'b0;
      case (r_state)
         S_WAIT: w = 1'b1;
         S_GETA: begin
            readnum = w_rn;
            loada   = 1'b1;
         end
         S_GETB: begin
            readnum = w_rm;
            loadb   = 1'b1;
         end
         S_ALU: begin
            shift = w_sh;
            loadc = 1'b1;
            // The ALU-group sub-opcode is exactly the ALU operation code; MOV reg passes B through 0+B.
            if (w_is_mov_reg) begin
               ALUop = 2'b00;
               asel  = 1'b1;
            end else begin
               ALUop = w_sub;
            end
`ifdef CPU_CTRL_STATUS_ALL_EN
            loads = 1'b1;
`else
            loads = w_is_cmp;
`endif
         end
         S_WREG: begin
            vsel     = 1'b0;
            write    = 1'b1;
            writenum = w_rd;
         end
         S_WIMM: begin
            vsel     = 1'b1;
            write    = 1'b1;
            writenum = w_rn;
         end
         default: w = 1'b0;
      endcase
   end

   assign datapath_in = {{8{r_ir[7]}}, r_ir[7:0]};
   assign bsel        = 1'b0;
   assign bad_op      = r_bad_op;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: per-cycle control vectors from a reference sequence model.
module tb_cpu_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] in_w;
   logic        load;
   logic        s;
   logic        w;
   logic        bad_op;
   logic [15:0] datapath_in;
   logic        vsel;
   logic [2:0]  writenum;
   logic        write;
   logic [2:0]  readnum;
   logic        loada;
   logic        loadb;
   logic [1:0]  shift;
   logic [1:0]  alu_op;
   logic        loadc;
   logic        loads;
   logic        asel;
   logic        bsel;
   logic [2:0]  dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   logic [19:0] exp_q[$];

   cpu_controller #(.RESET_IR(16'h0000)) dut (
      .clk(clk), .rst_n(rst_n), .in(in_w), .load(load), .s(s),
      .w(w), .bad_op(bad_op), .datapath_in(datapath_in), .vsel(vsel),
      .writenum(writenum), .write(write), .readnum(readnum), .loada(loada),
      .loadb(loadb), .shift(shift), .ALUop(alu_op), .loadc(loadc), .loads(loads),
      .asel(asel), .bsel(bsel), .o_dbg_state(dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   logic [19:0] obs_vec;
   assign obs_vec = {w, vsel, writenum, write, readnum, loada, loadb, shift, alu_op,
                     loadc, loads, asel, bsel, bad_op};

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [19:0] mk(input logic w_, input logic vs, input logic [2:0] wn,
                                      input logic wr, input logic [2:0] rn, input logic la,
                                      input logic lb, input logic [1:0] sh, input logic [1:0] op,
                                      input logic lc, input logic ls, input logic as_,
                                      input logic bo);
      return {w_, vs, wn, wr, rn, la, lb, sh, op, lc, ls, as_, 1'b0, bo};
   endfunction

   function automatic logic [19:0] idle(input logic bo);
      return mk(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, bo);
   endfunction

   function automatic logic [15:0] sx8(input logic [15:0] ir);
      return {{8{ir[7]}}, ir[7:0]};
   endfunction

   // Expected control vector for each cycle after the s edge, ending with the first w=1 cycle.
   task automatic push_expect(input logic [15:0] ir);
      logic [2:0] op, rn, rd, rm;
      logic [1:0] sub, sh;
      logic       mov_reg, ls_all;
      op = ir[15:13]; sub = ir[12:11]; rn = ir[10:8]; rd = ir[7:5]; sh = ir[4:3]; rm = ir[2:0];
`ifdef CPU_CTRL_STATUS_ALL_EN
      ls_all = 1'b1;
`else
      ls_all = 1'b0;
`endif
      mov_reg = (op == 3'b110) && (sub == 2'b00);
      if (op == 3'b110 && sub == 2'b10) begin
         exp_q.push_back(mk(0, 1, rn, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         exp_q.push_back(idle(1'b0));
      end else if (mov_reg || op == 3'b101) begin
         if (op == 3'b101 && sub != 2'b11)
            exp_q.push_back(mk(0, 0, 0, 0, rn, 1, 0, 0, 0, 0, 0, 0, 0));
         exp_q.push_back(mk(0, 0, 0, 0, rm, 0, 1, 0, 0, 0, 0, 0, 0));
         if (mov_reg)
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, sh, 2'b00, 1, ls_all, 1, 0));
         else
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, sh, sub, 1, ls_all | (sub == 2'b01), 0, 0));
         if (!(op == 3'b101 && sub == 2'b01))
            exp_q.push_back(mk(0, 0, rd, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         exp_q.push_back(idle(1'b0));
      end else begin
         exp_q.push_back(idle(1'b1));
         exp_q.push_back(idle(1'b0));
      end
   endtask

   // mode 0: load then s; mode 1: plus load/s during first step; mode 2: second load coincides with s
   task automatic exec(input logic [15:0] ir, input int mode, input logic [15:0] other);
      logic [19:0] exp;
      int          step;
      load = 1'b1; in_w = ir;
      @(posedge clk); #1;
      if (mode == 2) begin
         in_w = other;
      end else begin
         load = 1'b0; in_w = 16'($urandom);
      end
      s = 1'b1;
      push_expect(ir);
      @(posedge clk); #1;
      s = 1'b0; load = 1'b0;
      step = 0;
      while (exp_q.size() > 0) begin
         if (mode == 1 && step == 0) begin
            load = 1'b1; s = 1'b1; in_w = 16'h0000;
         end
         @(negedge clk);
         exp = exp_q.pop_front();
         check_eq($sformatf("ctl[%h].%0d", ir, step), 32'(obs_vec), 32'(exp));
         check_eq($sformatf("dpin[%h].%0d", ir, step), 32'(datapath_in), 32'(sx8(ir)));
         @(posedge clk); #1;
         load = 1'b0; s = 1'b0;
         step++;
      end
   endtask

   logic [15:0] r_instr;
   logic [2:0]  r_kind;

   initial begin
      rst_n = 1'b0; load = 1'b0; s = 1'b0; in_w = 16'h0000;
      #1;
      check_eq("reset_ctl", 32'(obs_vec), 32'(idle(1'b0)));
      check_eq("reset_dpin", 32'(datapath_in), 32'h0000);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      exec(16'hD0FD, 0, 16'h0);    // MOV R0,#-3
      exec(16'hA148, 0, 16'h0);    // ADD R2,R1,R0 LSL1
      exec(16'hA900, 0, 16'h0);    // CMP R1,R0
      exec(16'hB860, 1, 16'h0);    // MVN R3,R0 with ignored load/s mid-instruction
      exec(16'hE000, 0, 16'h0);    // unsupported
      exec(16'hC8A0, 0, 16'h0);    // unsupported sub-op in MOV group
      exec(16'hC0B3, 0, 16'h0);    // MOV R5,R3 LSL2
      exec(16'hD0FD, 2, 16'hA148); // same-cycle load+s runs the old IR

      // Random mix across all supported and unsupported encodings.
      for (int i = 0; i < 24; i++) begin
         r_kind = 3'($urandom_range(0, 4));
         r_instr = 16'($urandom);
         case (r_kind)
            3'd0: r_instr[15:11] = 5'b11010;
            3'd1: r_instr[15:11] = 5'b11000;
            3'd2: r_instr[15:13] = 3'b101;
            3'd3: r_instr[15:13] = 3'($urandom_range(0, 4));
            default: r_instr[15:11] = {3'b110, 1'($urandom_range(0, 1)), 1'b1};
         endcase
         exec(r_instr, 0, 16'h0);
      end

      // Reset mid-GETB aborts; no write appears while reset is held.
      load = 1'b1; in_w = 16'hA148;
      @(posedge clk); #1 load = 1'b0; s = 1'b1;
      @(posedge clk); #1 s = 1'b0;
      @(posedge clk); #1;
      check_eq("pre_reset_loadb", 32'(loadb), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("abort_ctl", 32'(obs_vec), 32'(idle(1'b0)));
      check_eq("abort_ir", 32'(datapath_in), 32'h0000);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check_eq("abort_write", 32'(write), 32'd0);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check_eq("post_reset_ctl", 32'(obs_vec), 32'(idle(1'b0)));
      exec(16'hA148, 0, 16'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
